// File: rtl/pwm_deadtime_pkg.sv
// Shared types for the dead-time PWM stage; encodings come from pwm_defs.vh.
package pwm_deadtime_pkg;

  `include "pwm_defs.vh"

  typedef enum logic [STATE_W-1:0] {
    IDLE     = ST_IDLE,
    HI_ON    = ST_HI_ON,
    DT_TO_LO = ST_DT_TO_LO,
    LO_ON    = ST_LO_ON,
    DT_TO_HI = ST_DT_TO_HI
  } state_t;

endpackage

// File: rtl/dt_timer.sv
// Dead-time down-counter: load wins, otherwise counts down and parks at zero.
module dt_timer #(
  parameter int unsigned DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DT_WIDTH-1:0] load_value,
  output logic [DT_WIDTH-1:0] value,
  output logic                zero
);

  logic [DT_WIDTH-1:0] value_next;

  always_comb begin
    value_next = value;
    if (load) begin
      value_next = load_value;
    end else if (!zero) begin
      value_next = value - DT_WIDTH'(1);
    end
  end

  // zero is registered alongside value so it always reflects the stored count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      zero  <= 1'b1;
    end else begin
      value <= value_next;
      zero  <= (value_next == '0);
    end
  end

endmodule

// File: rtl/pwm_defs.vh
// State encodings shared by the PWM output stages.
`ifndef PWM_DEFS_VH
`define PWM_DEFS_VH

localparam int unsigned STATE_W = 3;

localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
localparam logic [STATE_W-1:0] ST_HI_ON    = 3'd1;
localparam logic [STATE_W-1:0] ST_DT_TO_LO = 3'd2;
localparam logic [STATE_W-1:0] ST_LO_ON    = 3'd3;
localparam logic [STATE_W-1:0] ST_DT_TO_HI = 3'd4;

`endif

// File: rtl/pwm_deadtime.sv
// Complementary PWM driver with break-before-make dead time and period-aligned duty updates.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    count,
  input  logic [WIDTH-1:0]    duty_in,
  input  logic                duty_load,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                out_en,
  output logic                pwm_hi,
  output logic                pwm_lo,
  output logic                period_start,
  output logic [WIDTH-1:0]    duty_active
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] duty_pending;
  logic             pend_valid;
  logic             wrap_c;
  logic             raw_c;
  state_t           state;
  state_t           state_next;
  logic             dt_load;
  logic             dt_zero;
  logic [DT_WIDTH-1:0] dt_value;

  assign wrap_c = (count == '0) && (count_q != '0);
  assign raw_c  = (count < duty_active);

  // Duty double-buffer: pending value is promoted only at the period wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '1;
      period_start <= 1'b0;
      duty_active  <= '0;
      duty_pending <= '0;
      pend_valid   <= 1'b0;
    end else begin
      count_q      <= count;
      period_start <= wrap_c;
      if (wrap_c && pend_valid) begin
        duty_active <= duty_pending;
        pend_valid  <= 1'b0;
      end
      if (duty_load) begin
        duty_pending <= duty_in;
        pend_valid   <= 1'b1;
      end
    end
  end

  dt_timer #(
    .DT_WIDTH(DT_WIDTH)
  ) u_dt_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (dt_load),
    .load_value(deadtime),
    .value     (dt_value),
    .zero      (dt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dt_load    = 1'b0;
    if (!out_en) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_next = raw_c ? DT_TO_HI : DT_TO_LO;
          dt_load    = 1'b1;
        end
        HI_ON: begin
          if (!raw_c) begin
            state_next = DT_TO_LO;
            dt_load    = 1'b1;
          end
        end
        LO_ON: begin
          if (raw_c) begin
            state_next = DT_TO_HI;
            dt_load    = 1'b1;
          end
        end
        // A demand reversal mid-gap returns to the side that was just released
        DT_TO_LO: begin
          if (raw_c) begin
            state_next = HI_ON;
          end else if (dt_zero) begin
            state_next = LO_ON;
          end
        end
        DT_TO_HI: begin
          if (!raw_c) begin
            state_next = LO_ON;
          end else if (dt_zero) begin
            state_next = HI_ON;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Drives decode from the next state so they change on the same edge as state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      pwm_hi <= (state_next == HI_ON);
      pwm_lo <= (state_next == LO_ON);
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: duty update timing, dead-time gaps, boundaries, reset.
module tb_pwm_deadtime;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic [7:0] duty_in;
  logic       duty_load;
  logic [3:0] deadtime;
  logic       out_en;
  logic       pwm_hi;
  logic       pwm_lo;
  logic       period_start;
  logic [7:0] duty_active;

  int unsigned compared;
  int unsigned mismatched;
  logic [7:0]  last;

  pwm_deadtime #(
    .WIDTH   (8),
    .DT_WIDTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .duty_in     (duty_in),
    .duty_load   (duty_load),
    .deadtime    (deadtime),
    .out_en      (out_en),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .period_start(period_start),
    .duty_active (duty_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h (last count=%0d)", tag, observed, expected, last);
    end
  endtask

  // One clock: the edge samples the current count, then the counter advances
  task automatic step();
    @(posedge clk);
    #1;
    last  = count;
    count = count + 8'd1;
  endtask

  task automatic run_to(input logic [7:0] c);
    for (int i = 0; i < 300; i++) begin
      if (last == c) break;
      step();
    end
  endtask

  task automatic chk_out(input string tag, input logic hi, input logic lo);
    chk({tag, ".hi"}, 32'(pwm_hi), 32'(hi));
    chk({tag, ".lo"}, 32'(pwm_lo), 32'(lo));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    count      = 8'd250;
    last       = 8'd249;
    duty_in    = 8'd64;
    duty_load  = 1'b0;
    deadtime   = 4'd3;
    out_en     = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk_out("reset", 1'b0, 1'b0);
    chk("reset.ps", 32'(period_start), 32'd0);
    chk("reset.duty", 32'(duty_active), 32'd0);

    @(negedge clk);
    reset     = 1'b0;
    duty_load = 1'b1;
    out_en    = 1'b1;
    step();                          // samples 250: IDLE -> DT_TO_LO
    duty_load = 1'b0;
    chk_out("a.dt_lo", 1'b0, 1'b0);
    run_to(8'd253); chk_out("a.253", 1'b0, 1'b0);
    run_to(8'd254); chk_out("a.254", 1'b0, 1'b1);
    run_to(8'd0);
    chk("a.wrap.ps", 32'(period_start), 32'd1);
    chk("a.wrap.duty", 32'(duty_active), 32'd64);
    chk_out("a.wrap", 1'b0, 1'b1);
    run_to(8'd1);
    chk("a.1.ps", 32'(period_start), 32'd0);
    chk_out("a.1", 1'b0, 1'b0);
    run_to(8'd4);  chk_out("a.4", 1'b0, 1'b0);
    run_to(8'd5);  chk_out("a.5", 1'b1, 1'b0);
    run_to(8'd63); chk_out("a.63", 1'b1, 1'b0);
    run_to(8'd64); chk_out("a.64", 1'b0, 1'b0);
    run_to(8'd67); chk_out("a.67", 1'b0, 1'b0);
    run_to(8'd68); chk_out("a.68", 1'b0, 1'b1);
    run_to(8'd255); chk_out("a.255", 1'b0, 1'b1);
    run_to(8'd0);
    chk_out("a.p2.0", 1'b0, 1'b0);
    chk("a.p2.ps", 32'(period_start), 32'd1);
    run_to(8'd3); chk_out("a.p2.3", 1'b0, 1'b0);
    run_to(8'd4); chk_out("a.p2.4", 1'b1, 1'b0);

    // Mid-period load is held until the wrap; a load on the wrap edge is queued
    run_to(8'd99);
    duty_in   = 8'd128;
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
    chk("b.100.duty", 32'(duty_active), 32'd64);
    run_to(8'd255);
    chk("b.255.duty", 32'(duty_active), 32'd64);
    duty_in   = 8'd32;
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
    chk("b.wrap.duty", 32'(duty_active), 32'd128);
    chk("b.wrap.ps", 32'(period_start), 32'd1);
    run_to(8'd127); chk_out("b.127", 1'b1, 1'b0);
    run_to(8'd128); chk_out("b.128", 1'b0, 1'b0);
    run_to(8'd0);
    chk("b.wrap2.duty", 32'(duty_active), 32'd32);
    run_to(8'd31); chk_out("b.31", 1'b1, 1'b0);
    run_to(8'd32); chk_out("b.32", 1'b0, 1'b0);

    // Deadtime change inside a gap only affects the next gap
    deadtime = 4'd10;
    run_to(8'd35); chk_out("c.35", 1'b0, 1'b0);
    run_to(8'd36); chk_out("c.36", 1'b0, 1'b1);
    run_to(8'd255); chk_out("c.255", 1'b0, 1'b1);
    step();        chk_out("c.0", 1'b0, 1'b0);
    run_to(8'd10); chk_out("c.10", 1'b0, 1'b0);
    run_to(8'd11); chk_out("c.11", 1'b1, 1'b0);
    deadtime = 4'd3;

    // Output enable drop and restart
    run_to(8'd40); chk_out("d.40", 1'b0, 1'b1);
    out_en = 1'b0;
    step(); chk_out("d.off41", 1'b0, 1'b0);
    step(); chk_out("d.off42", 1'b0, 1'b0);
    out_en = 1'b1;
    step(); chk_out("d.on43", 1'b0, 1'b0);
    run_to(8'd46); chk_out("d.46", 1'b0, 1'b0);
    run_to(8'd47); chk_out("d.47", 1'b0, 1'b1);

    // Duty 0: high side never asserts
    duty_in   = 8'd0;
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
    run_to(8'd255); chk_out("e.255", 1'b0, 1'b1);
    step();
    chk("e.0.duty", 32'(duty_active), 32'd0);
    chk_out("e.0", 1'b0, 1'b0);
    step(); chk_out("e.1", 1'b0, 1'b1);
    for (int i = 2; i < 100; i++) begin
      step();
      chk_out("e.d0", 1'b0, 1'b1);
    end
    duty_in   = 8'd255;
    duty_load = 1'b1;
    step();
    duty_load = 1'b0;
    for (int i = 101; i < 256; i++) begin
      step();
      chk_out("e.d0b", 1'b0, 1'b1);
    end

    // Duty 255: one-clock dip at count 255, low side never asserts
    step();
    chk("f.0.duty", 32'(duty_active), 32'd255);
    chk_out("f.0", 1'b0, 1'b1);
    run_to(8'd4); chk_out("f.4", 1'b0, 1'b0);
    step();       chk_out("f.5", 1'b1, 1'b0);
    for (int i = 6; i < 255; i++) begin
      step();
      chk_out("f.d255", 1'b1, 1'b0);
    end
    step(); chk_out("f.255", 1'b0, 1'b0);
    step(); chk_out("f.0b", 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while driving high
    #3 reset = 1'b1;
    #1;
    chk_out("g.rst", 1'b0, 1'b0);
    chk("g.rst.ps", 32'(period_start), 32'd0);
    chk("g.rst.duty", 32'(duty_active), 32'd0);
    count = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("g.ps_after_reset", 32'(period_start), 32'd1);
    chk_out("g.0", 1'b0, 1'b0);
    step();
    chk("g.ps_clear", 32'(period_start), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter WIDTH, default 8: bit-width of the count, duty_in and duty_active.
REQ-002 Parameter DT_WIDTH, default 4: bit-width of deadtime.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 count  input  WIDTH  value from the upstream free-running up counter, which wraps from 2^WIDTH-1 to 0.
REQ-006 duty_in  input  WIDTH  requested duty, compared against count.
REQ-007 duty_load  input  1  one-clk strobe; captures duty_in into the pending register.
REQ-008 deadtime  input  DT_WIDTH  break-before-make gap, in clk cycles minus one.
REQ-009 out_en  input  1  output enable; 0 forces both outputs off.
REQ-010 pwm_hi  output  1  registered high-side drive.
REQ-011 pwm_lo  output  1  registered low-side drive.
REQ-012 period_start  output  1  registered one-clk pulse on count wrap to zero.
REQ-013 duty_active  output  WIDTH  duty currently in use.

Function
REQ-014 Block SHALL hold count_q, the registered previous count; period_start SHALL be 1 on the clk after the edge that samples count==0 with count_q!=0.
REQ-015 Block SHALL compute raw demand combinationally as raw = (count < duty_active), unsigned, WIDTH bits.
- duty 0: raw is always 0.
- duty 2^WIDTH-1: raw is 0 only when count is at maximum.
REQ-016 duty_load SHALL write duty_in to duty_pending and set pend_valid.
REQ-017 On each edge that samples the wrap condition of REQ-014 with pend_valid=1, duty_active SHALL take duty_pending and pend_valid SHALL clear.
REQ-018 If duty_load coincides with that edge:
- duty_active takes the old pending value;
- the new value is stored in duty_pending;
- pend_valid stays 1.
REQ-019 FSM states SHALL be IDLE, HI_ON, DT_TO_LO, LO_ON, DT_TO_HI.
REQ-020 Outputs SHALL decode from state: pwm_hi=1 only in HI_ON; pwm_lo=1 only in LO_ON; pwm_hi and pwm_lo SHALL never both be 1.
REQ-021 IDLE with out_en=1 SHALL go to DT_TO_HI if raw=1, else to DT_TO_LO, loading the dead-time counter with deadtime.
REQ-022 HI_ON with raw=0 SHALL go to DT_TO_LO, loading the dead-time counter with deadtime; LO_ON with raw=1 SHALL go to DT_TO_HI, loading the dead-time counter with deadtime.
REQ-023 In a DT state, each edge with counter=0 SHALL advance to the target ON state; otherwise the counter SHALL decrement. Both outputs are therefore low for deadtime+1 clks, and for 1 clk when deadtime=0.
REQ-024 DT_TO_LO with raw=1 SHALL return to HI_ON without waiting for the counter; DT_TO_HI with raw=0 SHALL return to LO_ON without waiting for the counter.
REQ-025 out_en=0 in any state SHALL go to IDLE on the next edge, taking priority over all other transitions.
REQ-026 deadtime SHALL be sampled only when a DT state is entered; changes during a DT state SHALL have no effect.

Reset
REQ-027 reset SHALL, asynchronously, set:
- state to IDLE;
- pwm_hi, pwm_lo and period_start to 0;
- duty_active, duty_pending and pend_valid to 0;
- the dead-time counter to 0;
- count_q to all-ones, so that count==0 after reset produces period_start.
REQ-028 Reset during a DT state SHALL drop both outputs immediately, with no dead-time completion.

Structure
REQ-029 State encodings SHALL be localparams in a shared include file, pwm_defs.vh, reused by future PWM stages.
REQ-030 The dead-time down-counter SHALL be a sub-module named dt_timer, with load, value, and a zero flag.

Verification (WIDTH=8, DT_WIDTH=4; count increments every clk unless stated)
REQ-031 Assert reset mid-run -> pwm_hi=0, pwm_lo=0, period_start=0, duty_active=0 within the same cycle, without waiting for a clock edge.
REQ-032 duty_load=64, deadtime=3, out_en=1 -> after the first wrap:
- pwm_hi high for count 0..63, delayed by the pipeline;
- both outputs low for 4 clks;
- pwm_lo high until the wrap;
- both outputs low for 4 clks before pwm_hi rises again.
REQ-033 duty_load=128 while count=100 with duty_active=64 -> duty_active stays 64 until period_start, then 128; duty_load on the period_start edge follows REQ-018.
REQ-034 Boundary duties, each with deadtime=3 and count incrementing every clk:
- duty=0 -> pwm_hi never asserts.
- duty=255 -> one-clk raw low at count 255; FSM enters DT_TO_LO then returns to HI_ON; pwm_lo never asserts.
REQ-035 out_en=0 while in LO_ON -> pwm_lo=0 next clk; out_en=1 again -> no output asserts for deadtime+1 clks.
REQ-036 Change deadtime from 3 to 10 while in DT_TO_LO -> gap remains 4 clks; the next transition uses an 11-clk gap.
